// File: rtl/coef_loader.sv
// coef_loader: double-buffered coefficient loader for a 16-tap FIR filter.
//   Coefficient words are written into a shadow bank. When a frame ends
//   (wr_last) with all 16 taps received, the frame waits in PEND until the
//   next sample boundary (sample_en). At that point the shadow bank is copied
//   into the active bank that drives the filter taps. Taps never change
//   mid-sample. A frame that ends with missing taps is dropped and raises a
//   sticky load_err.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   wr_valid/wr_ready   handshake for coefficient write words
//   wr_addr, wr_data    tap index 0..15 and signed coefficient value
//   wr_last             marks the final word of a coefficient frame
//   sample_en           one-cycle pulse at each filter sample boundary
//   coef[0:15]          active coefficient bank (registered outputs)
//   coef_valid          active bank holds a committed or default set
//   load_err            sticky: a frame ended with missing taps
//   frame_cnt           committed-frame counter (wraps at 256)
//
// Build option: define COEF_LOADER_IDENTITY_EN to reset the active bank to a
//   pass-through filter (coef[0]=16'h7FFF, all other taps 0, coef_valid=1).
module coef_loader (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [3:0]         wr_addr,
  input  logic signed [15:0] wr_data,
  input  logic               wr_last,
  input  logic               sample_en,
  output logic signed [15:0] coef [16],
  output logic               coef_valid,
  output logic               load_err,
  output logic [7:0]         frame_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_e;

  state_e             state_q, state_d;
  logic [15:0]        mask_q, mask_d;
  logic signed [15:0] shadow_q [16];
  logic signed [15:0] active_q [16];
  logic               coef_valid_q;
  logic               load_err_q;
  logic [7:0]         frame_cnt_q;

  logic               accept;
  logic               err_set;
  logic               commit;
  logic [15:0]        mask_new;

  // Next-state and control
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    err_set  = 1'b0;
    commit   = 1'b0;
    wr_ready = (state_q != PEND);
    accept   = wr_valid & wr_ready;
    mask_new = mask_q | (16'd1 << wr_addr);

    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          mask_d  = mask_new;
          state_d = LOAD;
          if (wr_last) begin
            if (&mask_new) begin
              state_d = PEND;
            end else begin
              // Incomplete frame: drop it, active bank untouched.
              err_set = 1'b1;
              mask_d  = '0;
              state_d = IDLE;
            end
          end
        end
      end
      PEND: begin
        if (sample_en) begin
          commit  = 1'b1;
          mask_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      load_err_q  <= 1'b0;
      frame_cnt_q <= '0;
`ifdef COEF_LOADER_IDENTITY_EN
      coef_valid_q <= 1'b1;
`else
      coef_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      if (err_set) begin
        load_err_q <= 1'b1;
      end
      if (commit) begin
        coef_valid_q <= 1'b1;
        frame_cnt_q  <= frame_cnt_q + 8'd1;
      end
    end
  end

  // Shadow bank: written on every accepted word, including words of a frame
  // that later turns out incomplete (the mask, not the data, gates a commit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '{default: '0};
    end else if (accept) begin
      shadow_q[wr_addr] <= wr_data;
    end
  end

  // Active bank: changes only on commit or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef COEF_LOADER_IDENTITY_EN
      active_q <= '{0: 16'sh7FFF, default: '0};
`else
      active_q <= '{default: '0};
`endif
    end else if (commit) begin
      active_q <= shadow_q;
    end
  end

  assign coef       = active_q;
  assign coef_valid = coef_valid_q;
  assign load_err   = load_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_coef_loader.sv
// Directed testbench for coef_loader. Each scenario task drives its own
// stimulus and checks the outputs against hand-computed values.
module tb_coef_loader;

  logic               clk;
  logic               rst_n;
  logic               wr_valid;
  logic               wr_ready;
  logic [3:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               wr_last;
  logic               sample_en;
  logic signed [15:0] coef [16];
  logic               coef_valid;
  logic               load_err;
  logic [7:0]         frame_cnt;

  int unsigned tests;
  int unsigned fails;

  logic signed [15:0] exp_c [16];
  logic               exp_rst_valid;

  coef_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .sample_en  (sample_en),
    .coef       (coef),
    .coef_valid (coef_valid),
    .load_err   (load_err),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset-time contents of the active bank
  task automatic set_reset_expect();
    for (int k = 0; k < 16; k++) exp_c[k] = '0;
`ifdef COEF_LOADER_IDENTITY_EN
    exp_c[0] = 16'sh7FFF;
    exp_rst_valid = 1'b1;
`else
    exp_rst_valid = 1'b0;
`endif
  endtask

  // Stimulus helpers; called at #1 after a rising edge, return likewise.
  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic l);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_last  = l;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic full_frame(input logic [15:0] base);
    for (int k = 0; k < 16; k++) wr(4'(k), base + 16'(k), (k == 15));
  endtask

  task automatic pulse_sample();
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    #1;
  endtask

  task automatic leave_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_reset_expect();
    enter_reset();
    #10;
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    tests++; if (coef_valid !== exp_rst_valid) begin fails++; $display("FAIL reset_coef_valid got=%b exp=%b", coef_valid, exp_rst_valid); end
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    for (int k = 0; k < 16; k++) begin
      tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL reset_coef[%0d] got=%h exp=%h", k, coef[k], exp_c[k]); end
    end
    leave_reset();
  endtask

  task automatic test_full_frame();
    full_frame(16'h0100);
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL pend_wr_ready got=%b exp=0", wr_ready); end
    for (int k = 0; k < 16; k++) begin
      tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL pend_coef_hold[%0d] got=%h exp=%h", k, coef[k], exp_c[k]); end
    end
    pulse_sample();
    for (int k = 0; k < 16; k++) exp_c[k] = 16'h0100 + 16'(k);
    for (int k = 0; k < 16; k++) begin
      tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL commit_coef[%0d] got=%h exp=%h", k, coef[k], exp_c[k]); end
    end
    tests++; if (coef_valid !== 1'b1) begin fails++; $display("FAIL commit_coef_valid got=%b exp=1", coef_valid); end
    tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL commit_frame_cnt got=%0d exp=1", frame_cnt); end
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL commit_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_stall();
    // sample_en in IDLE and mid-LOAD must not commit anything
    pulse_sample();
    for (int k = 0; k < 8; k++) wr(4'(k), 16'hF000 + 16'(k), 1'b0);
    pulse_sample();
    tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL ignore_sample_cnt got=%0d exp=1", frame_cnt); end
    tests++; if (coef[3] !== 16'sh0103) begin fails++; $display("FAIL ignore_sample_coef3 got=%h exp=0103", coef[3]); end
    for (int k = 8; k < 16; k++) wr(4'(k), 16'hF000 + 16'(k), (k == 15));
    // 20 idle sample periods in PEND; a write attempt must be stalled
    for (int c = 0; c < 20; c++) begin
      wr_valid = (c >= 10 && c < 13);
      wr_addr  = 4'd0;
      wr_data  = 16'sh5A5A;
      tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL stall_wr_ready cyc=%0d got=%b exp=0", c, wr_ready); end
      for (int k = 0; k < 16; k++) begin
        tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL stall_coef[%0d] cyc=%0d got=%h exp=%h", k, c, coef[k], exp_c[k]); end
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    pulse_sample();
    for (int k = 0; k < 16; k++) exp_c[k] = 16'hF000 + 16'(k);
    for (int k = 0; k < 16; k++) begin
      tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL stall_commit_coef[%0d] got=%h exp=%h", k, coef[k], exp_c[k]); end
    end
    tests++; if (frame_cnt !== 8'd2) begin fails++; $display("FAIL stall_frame_cnt got=%0d exp=2", frame_cnt); end
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL stall_wr_ready_back got=%b exp=1", wr_ready); end
  endtask

  task automatic test_missing_tap();
    for (int k = 0; k < 15; k++) wr(4'(k), 16'h8000 + 16'(k), (k == 14));
    tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL miss_load_err got=%b exp=1", load_err); end
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL miss_wr_ready got=%b exp=1", wr_ready); end
    pulse_sample();
    tests++; if (frame_cnt !== 8'd2) begin fails++; $display("FAIL miss_frame_cnt got=%0d exp=2", frame_cnt); end
    for (int k = 0; k < 16; k++) begin
      tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL miss_coef[%0d] got=%h exp=%h", k, coef[k], exp_c[k]); end
    end
    // single-word frame is also incomplete
    wr(4'd3, 16'h1234, 1'b1);
    pulse_sample();
    tests++; if (frame_cnt !== 8'd2) begin fails++; $display("FAIL single_frame_cnt got=%0d exp=2", frame_cnt); end
    tests++; if (coef[3] !== exp_c[3]) begin fails++; $display("FAIL single_coef3 got=%h exp=%h", coef[3], exp_c[3]); end
    // a good frame still commits; load_err stays set
    full_frame(16'h0200);
    pulse_sample();
    for (int k = 0; k < 16; k++) exp_c[k] = 16'h0200 + 16'(k);
    tests++; if (frame_cnt !== 8'd3) begin fails++; $display("FAIL miss_after_cnt got=%0d exp=3", frame_cnt); end
    tests++; if (coef[15] !== exp_c[15]) begin fails++; $display("FAIL miss_after_coef15 got=%h exp=%h", coef[15], exp_c[15]); end
    tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL load_err_sticky got=%b exp=1", load_err); end
  endtask

  task automatic test_wrap_dup();
    @(posedge clk); #1;
    enter_reset();
    leave_reset();
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_start_cnt got=%0d exp=0", frame_cnt); end
    for (int n = 0; n < 255; n++) begin
      full_frame(16'(n << 4));
      pulse_sample();
    end
    tests++; if (frame_cnt !== 8'd255) begin fails++; $display("FAIL wrap_cnt_255 got=%0d exp=255", frame_cnt); end
    // last frame: addr 5 written twice, last write wins
    for (int k = 0; k < 15; k++) wr(4'(k), (k == 5) ? 16'h1111 : 16'h0FF0 + 16'(k), 1'b0);
    wr(4'd5, 16'h2222, 1'b0);
    wr(4'd15, 16'h0FFF, 1'b1);
    pulse_sample();
    for (int k = 0; k < 16; k++) exp_c[k] = (k == 5) ? 16'sh2222 : 16'h0FF0 + 16'(k);
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_cnt_0 got=%0d exp=0", frame_cnt); end
    for (int k = 0; k < 16; k++) begin
      tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL dup_coef[%0d] got=%h exp=%h", k, coef[k], exp_c[k]); end
    end
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL wrap_load_err got=%b exp=0", load_err); end
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < 8; k++) wr(4'(k), 16'h3000 + 16'(k), 1'b0);
    enter_reset();
    set_reset_expect();
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL midrst_wr_ready got=%b exp=1", wr_ready); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL midrst_frame_cnt got=%0d exp=0", frame_cnt); end
    tests++; if (coef_valid !== exp_rst_valid) begin fails++; $display("FAIL midrst_coef_valid got=%b exp=%b", coef_valid, exp_rst_valid); end
    for (int k = 0; k < 16; k++) begin
      tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL midrst_coef[%0d] got=%h exp=%h", k, coef[k], exp_c[k]); end
    end
    leave_reset();
    // mask was discarded: the second half alone is an incomplete frame
    for (int k = 8; k < 16; k++) wr(4'(k), 16'h4000 + 16'(k), (k == 15));
    tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL midrst_half_err got=%b exp=1", load_err); end
    pulse_sample();
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL midrst_half_cnt got=%0d exp=0", frame_cnt); end
    tests++; if (coef[8] !== exp_c[8]) begin fails++; $display("FAIL midrst_half_coef8 got=%h exp=%h", coef[8], exp_c[8]); end
    full_frame(16'h0500);
    pulse_sample();
    for (int k = 0; k < 16; k++) exp_c[k] = 16'h0500 + 16'(k);
    for (int k = 0; k < 16; k++) begin
      tests++; if (coef[k] !== exp_c[k]) begin fails++; $display("FAIL midrst_commit_coef[%0d] got=%h exp=%h", k, coef[k], exp_c[k]); end
    end
    tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL midrst_commit_cnt got=%0d exp=1", frame_cnt); end
    tests++; if (coef_valid !== 1'b1) begin fails++; $display("FAIL midrst_commit_valid got=%b exp=1", coef_valid); end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_last   = 1'b0;
    sample_en = 1'b0;
    test_reset();
    test_full_frame();
    test_stall();
    test_missing_tap();
    test_wrap_dup();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coef_loader.md
COEF_LOADER -- requirements
Module: coef_loader

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port wr_valid  input  1  coefficient write word valid.
REQ-004 SHALL have port wr_ready  output  1  block can accept a write word.
REQ-005 SHALL have port wr_addr  input  4  tap index 0..15.
REQ-006 SHALL have port wr_data  input  16  signed coefficient value.
REQ-007 SHALL have port wr_last  input  1  marks the final word of a coefficient frame.
REQ-008 SHALL have port sample_en  input  1  one-cycle pulse at each filter sample boundary.
REQ-009 SHALL have port coef  output  16x16  signed active coefficient array, index 0..15, feeding the FIR filter taps.
REQ-010 SHALL have port coef_valid  output  1  active bank holds a committed or default set.
REQ-011 SHALL have port load_err  output  1  sticky error: frame ended with missing taps.
REQ-012 SHALL have port frame_cnt  output  8  count of committed frames.

Function
REQ-013 SHALL hold a 16x16 shadow bank, a 16x16 active bank, and a 16-bit received-tap mask.
REQ-014 SHALL implement FSM states IDLE, LOAD, PEND.
REQ-015 SHALL drive wr_ready=1 in IDLE and LOAD and wr_ready=0 in PEND.
REQ-016 SHALL accept a word only when wr_valid and wr_ready are both 1 in the same cycle.
REQ-017 On an accepted word, SHALL write shadow[wr_addr]=wr_data and set mask[wr_addr]; IDLE moves to LOAD.
REQ-018 SHALL allow duplicate addresses within a frame; the last write wins.
REQ-019 On an accepted word with wr_last=1 and the mask (including this word) all ones, SHALL go to PEND.
REQ-020 On an accepted word with wr_last=1 and any mask bit clear, SHALL set load_err, clear the mask and go to IDLE; the active bank is unchanged.
REQ-021 A single-word frame (wr_last on first word) SHALL follow REQ-020 rules.
REQ-022 In PEND on sample_en=1, SHALL copy shadow to active, set coef_valid=1, increment frame_cnt (255 wraps to 0), clear the mask and return to IDLE.
REQ-023 The new coef values SHALL be visible on the cycle after the sample_en cycle; coef SHALL never change except on a commit or reset.
REQ-024 In IDLE and LOAD, sample_en SHALL be ignored.
REQ-025 In PEND, wr_valid SHALL be ignored (stalled by wr_ready=0).
REQ-026 coef SHALL be driven directly from active-bank registers with no combinational path from inputs.
REQ-027 load_err SHALL clear only on reset.

Reset
REQ-028 On rst_n=0, SHALL immediately set state IDLE, mask 0, shadow 0, load_err 0 and frame_cnt 0; active bank and coef_valid are set per REQ-030/031.
REQ-029 Reset during LOAD or PEND SHALL discard the partial or pending frame.

Configuration
REQ-030 With macro COEF_LOADER_IDENTITY_EN defined, reset SHALL set active coef[0]=16'h7FFF, all other taps 0, and coef_valid=1 (pass-through filter).
REQ-031 Without COEF_LOADER_IDENTITY_EN, reset SHALL set all active taps to 0 and coef_valid=0.

Verification
REQ-032 Reset, then write addr 0..15 with data 16'h0100+addr, last on addr 15, then pulse sample_en -> coef[k]=16'h0100+k from the next cycle; coef_valid=1; frame_cnt=1.
REQ-033 Write a full frame, then hold sample_en low 20 cycles -> wr_ready=0 and coef unchanged throughout; after sample_en pulses, swap occurs and wr_ready returns to 1.
REQ-034 Frame of addrs 0..14 with last on addr 14 -> load_err=1, coef unchanged, frame_cnt unchanged, state IDLE.
REQ-035 Commit 256 full frames -> frame_cnt wraps to 0; with addr 5 written twice (16'h1111 then 16'h2222) in the last frame -> coef[5]=16'h2222.
REQ-036 Assert rst_n=0 mid-LOAD after 8 words -> state returns to IDLE and a subsequent full frame commits correctly; coef after reset is the identity set if COEF_LOADER_IDENTITY_EN is defined, else all 0 with coef_valid=0.
